// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard ASCII path.
// Contents: set-2 scan-code constants, modifier tag bit positions,
// FSM state encoding and the ASCII table entry layout.
package ps2_kbd_pkg;

  localparam logic [7:0] CAPS  = 8'h58;
  localparam logic [7:0] BREAK = 8'hF0;

  // Bit positions inside the 6-bit modifier tag {RShift,RCtrl,RAlt,LShift,LCtrl,LAlt}
  localparam int unsigned TAG_LALT   = 0;
  localparam int unsigned TAG_LCTRL  = 1;
  localparam int unsigned TAG_LSHIFT = 2;
  localparam int unsigned TAG_RALT   = 3;
  localparam int unsigned TAG_RCTRL  = 4;
  localparam int unsigned TAG_RSHIFT = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PUSH
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       is_letter;
    logic [6:0] ascii;
  } rom_entry_t;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Registered 512x9 scan-code to ASCII table.
// Ports:
//   clk_i   - clock
//   addr_i  - {shift, scan code}
//   data_o  - {valid, is_letter, ascii[6:0]}, one cycle after addr_i
// Letters always return lower case; case folding is done by the consumer.
module ps2_ascii_rom
  import ps2_kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic [8:0] addr_i,
  output rom_entry_t data_o
);

  rom_entry_t entry_d;
  rom_entry_t entry_q;
  logic       shift;

  function automatic rom_entry_t letter(input logic [6:0] a);
    return '{valid: 1'b1, is_letter: 1'b1, ascii: a};
  endfunction

  function automatic rom_entry_t sym(input logic s, input logic [6:0] lo, input logic [6:0] hi);
    return '{valid: 1'b1, is_letter: 1'b0, ascii: (s ? hi : lo)};
  endfunction

  assign shift = addr_i[8];

  always_comb begin
    entry_d = '0;
    unique case (addr_i[7:0])
      8'h1C: entry_d = letter(7'h61);
      8'h32: entry_d = letter(7'h62);
      8'h21: entry_d = letter(7'h63);
      8'h23: entry_d = letter(7'h64);
      8'h24: entry_d = letter(7'h65);
      8'h2B: entry_d = letter(7'h66);
      8'h34: entry_d = letter(7'h67);
      8'h33: entry_d = letter(7'h68);
      8'h43: entry_d = letter(7'h69);
      8'h3B: entry_d = letter(7'h6A);
      8'h42: entry_d = letter(7'h6B);
      8'h4B: entry_d = letter(7'h6C);
      8'h3A: entry_d = letter(7'h6D);
      8'h31: entry_d = letter(7'h6E);
      8'h44: entry_d = letter(7'h6F);
      8'h4D: entry_d = letter(7'h70);
      8'h15: entry_d = letter(7'h71);
      8'h2D: entry_d = letter(7'h72);
      8'h1B: entry_d = letter(7'h73);
      8'h2C: entry_d = letter(7'h74);
      8'h3C: entry_d = letter(7'h75);
      8'h2A: entry_d = letter(7'h76);
      8'h1D: entry_d = letter(7'h77);
      8'h22: entry_d = letter(7'h78);
      8'h35: entry_d = letter(7'h79);
      8'h1A: entry_d = letter(7'h7A);
      8'h16: entry_d = sym(shift, 7'h31, 7'h21);
      8'h1E: entry_d = sym(shift, 7'h32, 7'h40);
      8'h26: entry_d = sym(shift, 7'h33, 7'h23);
      8'h25: entry_d = sym(shift, 7'h34, 7'h24);
      8'h2E: entry_d = sym(shift, 7'h35, 7'h25);
      8'h36: entry_d = sym(shift, 7'h36, 7'h5E);
      8'h3D: entry_d = sym(shift, 7'h37, 7'h26);
      8'h3E: entry_d = sym(shift, 7'h38, 7'h2A);
      8'h46: entry_d = sym(shift, 7'h39, 7'h28);
      8'h45: entry_d = sym(shift, 7'h30, 7'h29);
      8'h4E: entry_d = sym(shift, 7'h2D, 7'h5F);
      8'h55: entry_d = sym(shift, 7'h3D, 7'h2B);
      8'h54: entry_d = sym(shift, 7'h5B, 7'h7B);
      8'h5B: entry_d = sym(shift, 7'h5D, 7'h7D);
      8'h5D: entry_d = sym(shift, 7'h5C, 7'h7C);
      8'h4C: entry_d = sym(shift, 7'h3B, 7'h3A);
      8'h52: entry_d = sym(shift, 7'h27, 7'h22);
      8'h41: entry_d = sym(shift, 7'h2C, 7'h3C);
      8'h49: entry_d = sym(shift, 7'h2E, 7'h3E);
      8'h4A: entry_d = sym(shift, 7'h2F, 7'h3F);
      8'h0E: entry_d = sym(shift, 7'h60, 7'h7E);
      8'h29: entry_d = sym(shift, 7'h20, 7'h20);
      8'h5A: entry_d = sym(shift, 7'h0D, 7'h0D);
      8'h66: entry_d = sym(shift, 7'h08, 7'h08);
      8'h0D: entry_d = sym(shift, 7'h09, 7'h09);
      8'h76: entry_d = sym(shift, 7'h1B, 7'h1B);
      default: entry_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  assign data_o = entry_q;

endmodule

// File: rtl/ps2keyboard_ascii_funcmod.sv
// PS/2 keyboard make-code to ASCII converter with character FIFO.
// Ports:
//   CLOCK, RESET (sync, active-low)
//   iTrig/iData/iTag  - new make code pulse, scan code, modifier levels
//   iRead             - pop FIFO head (ignored when empty)
//   iClearOvf         - clear sticky overflow flag
//   oData             - FWFT head {1'b0,ascii}; last popped value when empty
//   oEmpty/oFull/oCount - FIFO status
//   oCaps             - Caps Lock state
//   oOverflow         - sticky: a character was dropped on a full FIFO
module ps2keyboard_ascii_funcmod
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              iTrig,
  input  logic [7:0]        iData,
  input  logic [5:0]        iTag,
  input  logic              iRead,
  input  logic              iClearOvf,
  output logic [7:0]        oData,
  output logic              oEmpty,
  output logic              oFull,
  output logic [ADDR_W:0]   oCount,
  output logic              oCaps,
  output logic              oOverflow
);

  state_e state_q, state_d;

  logic [7:0]        code_q;
  logic              shift_q;
  logic              ctrl_q;
  logic              caps_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [6:0]        hold_q;
  logic [6:0]        mem [DEPTH];

  logic       capture_en;
  logic       push_phase;
  logic       push_req;
  logic       wr_en;
  logic       rd_en;
  logic       drop;
  logic       is_caps;
  logic [6:0] char_d;
  rom_entry_t rom_q;
  logic       unused_alt;

  assign unused_alt = ^{iTag[TAG_LALT], iTag[TAG_RALT]};

  ps2_ascii_rom u_rom (
    .clk_i  (CLOCK),
    .addr_i ({shift_q, code_q}),
    .data_o (rom_q)
  );

  // FSM state register
  always_ff @(posedge CLOCK) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a stray break prefix is never a character, so it is not even looked up
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (iTrig && iData != BREAK) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_PUSH;
      ST_PUSH:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture_en = 1'b0;
    push_phase = 1'b0;
    unique case (state_q)
      ST_IDLE:  capture_en = iTrig && (iData != BREAK);
      ST_PUSH:  push_phase = 1'b1;
      default: ;
    endcase
  end

  // Character formation: letters are stored lower case, bit 5 cleared for upper
  always_comb begin
    char_d = rom_q.ascii;
    if (rom_q.is_letter) begin
      if (ctrl_q)                char_d = {2'b00, rom_q.ascii[4:0]};
      else if (shift_q ^ caps_q) char_d = rom_q.ascii & 7'h5F;
    end
  end

  assign is_caps  = (code_q == CAPS);
  assign push_req = push_phase && !is_caps && rom_q.valid;
  assign rd_en    = iRead && !oEmpty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds
  assign wr_en    = push_req && (!oFull || rd_en);
  assign drop     = push_req && oFull && !rd_en;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      code_q  <= '0;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      caps_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (capture_en) begin
        code_q  <= iData;
        shift_q <= iTag[TAG_LSHIFT] | iTag[TAG_RSHIFT];
        ctrl_q  <= iTag[TAG_LCTRL]  | iTag[TAG_RCTRL];
      end
      if (push_phase && is_caps) caps_q <= ~caps_q;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) begin
        rptr_q <= rptr_q + 1'b1;
        hold_q <= mem[rptr_q];
      end
      count_q <= count_d;
      if (drop)           ovf_q <= 1'b1;
      else if (iClearOvf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET && wr_en) mem[wptr_q] <= char_d;
  end

  assign oEmpty    = (count_q == '0);
  assign oFull     = (count_q == (ADDR_W+1)'(DEPTH));
  assign oCount    = count_q;
  assign oCaps     = caps_q;
  assign oOverflow = ovf_q;
  // Empty FIFO shows the last popped character (zero after reset), never stale memory
  assign oData     = oEmpty ? {1'b0, hold_q} : {1'b0, mem[rptr_q]};

endmodule

// File: tb/tb_ps2keyboard_ascii_funcmod.sv
module tb_ps2keyboard_ascii_funcmod;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       iTrig = 1'b0;
  logic [7:0] iData = '0;
  logic [5:0] iTag  = '0;
  logic       iRead = 1'b0;
  logic       iClearOvf = 1'b0;
  logic [7:0] oData;
  logic       oEmpty;
  logic       oFull;
  logic [4:0] oCount;
  logic       oCaps;
  logic       oOverflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  bit auto_read = 1'b0;
  bit raw_read  = 1'b0;
  int req_pops  = 0;
  int done_pops = 0;

  logic [7:0] codes_a_p [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};

  ps2keyboard_ascii_funcmod #(.DEPTH(16), .ADDR_W(4)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .iTrig     (iTrig),
    .iData     (iData),
    .iTag      (iTag),
    .iRead     (iRead),
    .iClearOvf (iClearOvf),
    .oData     (oData),
    .oEmpty    (oEmpty),
    .oFull     (oFull),
    .oCount    (oCount),
    .oCaps     (oCaps),
    .oOverflow (oOverflow)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [7:0] code, input logic [5:0] tag, input bit has, input logic [7:0] ch);
    if (has) exp_q.push_back(ch);
    iData = code;
    iTag  = tag;
    iTrig = 1'b1;
    tick(1);
    iTrig = 1'b0;
    tick(3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && oEmpty) break;
      tick(1);
    end
    check("drain", {15'd0, (exp_q.size() == 0 && oEmpty)}, 16'd1);
  endtask

  // Monitor: pops the FIFO head when reading is enabled and scores it against the queue
  initial begin
    forever begin
      logic [7:0] e;
      @(negedge CLOCK);
      if (!RESET) begin
        iRead = 1'b0;
      end else if ((auto_read || done_pops < req_pops) && !oEmpty) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL fifo_head: got %0h want <nothing queued>", oData);
        end else begin
          e = exp_q.pop_front();
          if (oData !== e) begin
            n_err++;
            $display("FAIL fifo_head: got %0h want %0h", oData, e);
          end
        end
        if (!auto_read) done_pops++;
        iRead = 1'b1;
      end else begin
        iRead = raw_read;
      end
    end
  end

  initial begin
    // Reset state
    RESET = 1'b0;
    tick(3);
    check("rst_empty", {15'd0, oEmpty}, 16'd1);
    check("rst_full",  {15'd0, oFull}, 16'd0);
    check("rst_count", {11'd0, oCount}, 16'd0);
    check("rst_data",  {8'd0, oData}, 16'h0000);
    check("rst_caps",  {15'd0, oCaps}, 16'd0);
    check("rst_ovf",   {15'd0, oOverflow}, 16'd0);
    RESET = 1'b1;
    tick(1);

    // Latency of first character
    exp_q.push_back(8'h61);
    iData = 8'h1C; iTag = '0; iTrig = 1'b1;
    tick(1);
    iTrig = 1'b0;
    check("lat_empty_n1", {15'd0, oEmpty}, 16'd1);
    tick(1);
    check("lat_empty_n2", {15'd0, oEmpty}, 16'd1);
    tick(1);
    check("lat_empty_n3", {15'd0, oEmpty}, 16'd0);
    check("lat_data",     {8'd0, oData}, 16'h0061);
    check("lat_count",    {11'd0, oCount}, 16'd1);
    req_pops++;
    tick(2);
    check("pop_empty", {15'd0, oEmpty}, 16'd1);

    // Modifiers and caps lock
    auto_read = 1'b1;
    send(8'h1C, 6'b000100, 1, 8'h41);
    send(8'h16, 6'b100000, 1, 8'h21);
    send(8'h58, 6'b000000, 0, 8'h00);
    check("caps_on", {15'd0, oCaps}, 16'd1);
    send(8'h1C, 6'b000000, 1, 8'h41);
    send(8'h1C, 6'b000100, 1, 8'h61);
    send(8'h16, 6'b000000, 1, 8'h31);
    send(8'h58, 6'b000000, 0, 8'h00);
    check("caps_off", {15'd0, oCaps}, 16'd0);
    send(8'h1C, 6'b000010, 1, 8'h01);
    send(8'h1A, 6'b010000, 1, 8'h1A);
    send(8'h1C, 6'b000001, 1, 8'h61);
    send(8'h05, 6'b000000, 0, 8'h00);
    send(8'h4E, 6'b000100, 1, 8'h5F);
    send(8'h0E, 6'b100000, 1, 8'h7E);
    send(8'h29, 6'b000000, 1, 8'h20);
    send(8'h5A, 6'b000000, 1, 8'h0D);
    send(8'h76, 6'b000000, 1, 8'h1B);
    wait_drain();
    check("mix_count", {11'd0, oCount}, 16'd0);

    // Fill, overflow, clear
    auto_read = 1'b0;
    for (int i = 0; i < 16; i++) send(codes_a_p[i], 6'b000000, 1, 8'h61 + 8'(i));
    check("full_flag",  {15'd0, oFull}, 16'd1);
    check("full_count", {11'd0, oCount}, 16'd16);
    send(8'h15, 6'b000000, 0, 8'h00);
    check("ovf_set",     {15'd0, oOverflow}, 16'd1);
    check("ovf_count",   {11'd0, oCount}, 16'd16);
    iClearOvf = 1'b1;
    tick(1);
    iClearOvf = 1'b0;
    check("ovf_clear", {15'd0, oOverflow}, 16'd0);

    // Push into a full FIFO with a pop in the same cycle
    exp_q.push_back(8'h7A);
    iData = 8'h1A; iTag = '0; iTrig = 1'b1;
    tick(1);
    iTrig = 1'b0;
    tick(1);
    req_pops++;
    tick(1);
    check("pp_count", {11'd0, oCount}, 16'd16);
    check("pp_full",  {15'd0, oFull}, 16'd1);
    tick(1);
    check("pp_ovf",   {15'd0, oOverflow}, 16'd0);
    auto_read = 1'b1;
    wait_drain();
    check("pp_drain_count", {11'd0, oCount}, 16'd0);

    // Read on empty FIFO
    raw_read = 1'b1;
    tick(1);
    raw_read = 1'b0;
    tick(1);
    check("rd_empty_count", {11'd0, oCount}, 16'd0);
    check("rd_empty_flag",  {15'd0, oEmpty}, 16'd1);
    send(8'h21, 6'b000000, 1, 8'h63);
    wait_drain();
    check("hold_last", {8'd0, oData}, 16'h0063);

    // Reset during lookup with entries queued
    auto_read = 1'b0;
    send(8'h58, 6'b000000, 0, 8'h00);
    for (int i = 0; i < 5; i++) send(codes_a_p[i], 6'b000000, 1, 8'h41 + 8'(i));
    check("pre_rst_count", {11'd0, oCount}, 16'd5);
    check("pre_rst_caps",  {15'd0, oCaps}, 16'd1);
    iData = 8'h1C; iTag = '0; iTrig = 1'b1;
    tick(1);
    iTrig = 1'b0;
    RESET = 1'b0;
    tick(1);
    RESET = 1'b1;
    exp_q.delete();
    check("mid_rst_count", {11'd0, oCount}, 16'd0);
    check("mid_rst_empty", {15'd0, oEmpty}, 16'd1);
    check("mid_rst_caps",  {15'd0, oCaps}, 16'd0);
    check("mid_rst_data",  {8'd0, oData}, 16'h0000);
    tick(3);
    check("post_rst_nowrite", {11'd0, oCount}, 16'd0);
    auto_read = 1'b1;
    send(8'h1C, 6'b000000, 1, 8'h61);
    wait_drain();

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
